// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the decode-side ALU control interface: ALU_OP codes,
// RV32 opcode / funct3 / funct7 values and the decoded-bundle width.
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

    // ALU operation codes seen by the execute stage
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_SRAI = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_ABS  = 3'b101;

    // Major opcodes
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

    // funct3 values
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Bundle = {alu_op(3), imm(N), src_imm(1), rs1(5), rs2(5), rd(5), illegal(1)}
    localparam int unsigned BUNDLE_CTRL_W = 3 + 1 + 5 + 5 + 5 + 1;

    function automatic int unsigned bundle_w(input int unsigned n);
        return BUNDLE_CTRL_W + n;
    endfunction

endpackage

// File: rtl/alu_op_encode.sv
// ----------------------------------------------------------------------------
// alu_op_encode
// Purely combinational decoder from an RV32 instruction word to the ALU
// control bundle. Optional feature macro: ALU_ABS_EN (custom-0 ABS encoding).
// Ports:
//   i_instr     32-bit instruction word
//   o_alu_op    ALU operation code
//   o_imm       sign-extended I-type immediate, zero otherwise
//   o_src_imm   B operand is the immediate
//   o_rs1/o_rs2/o_rd  register indices (rd and rs2 zeroed where not used)
//   o_illegal   word is outside the decoded subset
// ----------------------------------------------------------------------------
module alu_op_encode
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [31:0]  i_instr,
    output logic [2:0]   o_alu_op,
    output logic [N-1:0] o_imm,
    output logic         o_src_imm,
    output logic [4:0]   o_rs1,
    output logic [4:0]   o_rs2,
    output logic [4:0]   o_rd,
    output logic         o_illegal
);

    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    logic [N-1:0] w_imm_sext;
    logic         w_legal;

    assign w_opcode   = i_instr[6:0];
    assign w_funct3   = i_instr[14:12];
    assign w_funct7   = i_instr[31:25];
    assign w_imm_sext = {{(N-12){i_instr[31]}}, i_instr[31:20]};

    always_comb begin
        w_legal   = 1'b0;
        o_alu_op  = ALU_ADD;
        o_imm     = '0;
        o_src_imm = 1'b0;
        o_rs1     = i_instr[19:15];
        o_rs2     = '0;
        o_rd      = i_instr[11:7];

        case (w_opcode)
            OPC_OP: begin
                o_rs2 = i_instr[24:20];
                if (w_funct7 == F7_BASE) begin
                    case (w_funct3)
                        F3_ADD: begin w_legal = 1'b1; o_alu_op = ALU_ADD; end
                        F3_AND: begin w_legal = 1'b1; o_alu_op = ALU_AND; end
                        F3_XOR: begin w_legal = 1'b1; o_alu_op = ALU_XOR; end
                        default: ;
                    endcase
                end else if (w_funct7 == F7_ALT && w_funct3 == F3_ADD) begin
                    w_legal  = 1'b1;
                    o_alu_op = ALU_SUB;
                end
            end
            OPC_OPIMM: begin
                o_imm     = w_imm_sext;
                o_src_imm = 1'b1;
                case (w_funct3)
                    F3_ADD: begin w_legal = 1'b1; o_alu_op = ALU_ADD; end
                    F3_AND: begin w_legal = 1'b1; o_alu_op = ALU_AND; end
                    F3_XOR: begin w_legal = 1'b1; o_alu_op = ALU_XOR; end
                    F3_SR: begin
                        // Only the arithmetic form; SRLI (funct7 0) is not in the subset
                        if (w_funct7 == F7_ALT) begin
                            w_legal  = 1'b1;
                            o_alu_op = ALU_SRAI;
                        end
                    end
                    default: ;
                endcase
            end
`ifdef ALU_ABS_EN
            OPC_CUSTOM0: begin
                if (w_funct3 == F3_ADD && w_funct7 == F7_BASE) begin
                    w_legal  = 1'b1;
                    o_alu_op = ALU_ABS;
                end
            end
`endif
            default: ;
        endcase

        // Illegal words travel down as a harmless no-writeback bundle
        if (!w_legal) begin
            o_alu_op  = ALU_ADD;
            o_imm     = '0;
            o_src_imm = 1'b0;
            o_rs2     = '0;
            o_rd      = '0;
        end
        o_illegal = ~w_legal;
    end

endmodule

// File: rtl/alu_op_decoder.sv
// ----------------------------------------------------------------------------
// alu_op_decoder
// Decode stage producing the registered ALU control bundle for execute.
// A two-entry skid buffer (main + skid register) keeps i-side ready
// registered while sustaining one word per cycle. Optional feature macro:
// ALU_ABS_EN (passed through to alu_op_encode).
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_flush             synchronous kill of both buffered entries
//   i_in_valid/o_in_ready, i_instr     fetch-side handshake and word
//   o_out_valid/i_out_ready            execute-side handshake
//   o_alu_op, o_imm, o_src_imm, o_rs1, o_rs2, o_rd, o_illegal  bundle
// ----------------------------------------------------------------------------
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [31:0]  i_instr,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [2:0]   o_alu_op,
    output logic [N-1:0] o_imm,
    output logic         o_src_imm,
    output logic [4:0]   o_rs1,
    output logic [4:0]   o_rs2,
    output logic [4:0]   o_rd,
    output logic         o_illegal
);

    localparam int unsigned BW = bundle_w(N);

    logic [2:0]   w_alu_op;
    logic [N-1:0] w_imm;
    logic         w_src_imm;
    logic [4:0]   w_rs1;
    logic [4:0]   w_rs2;
    logic [4:0]   w_rd;
    logic         w_illegal;
    logic [BW-1:0] w_enc;

    logic          r_main_valid;
    logic [BW-1:0] r_main_data;
    logic          r_skid_valid;
    logic [BW-1:0] r_skid_data;

    logic          w_main_valid_nxt;
    logic [BW-1:0] w_main_data_nxt;
    logic          w_skid_valid_nxt;
    logic [BW-1:0] w_skid_data_nxt;
    logic          w_accept;
    logic          w_main_free;

    alu_op_encode #(
        .N (N)
    ) u_encode (
        .i_instr   (i_instr),
        .o_alu_op  (w_alu_op),
        .o_imm     (w_imm),
        .o_src_imm (w_src_imm),
        .o_rs1     (w_rs1),
        .o_rs2     (w_rs2),
        .o_rd      (w_rd),
        .o_illegal (w_illegal)
    );

    assign w_enc = {w_alu_op, w_imm, w_src_imm, w_rs1, w_rs2, w_rd, w_illegal};

    assign o_in_ready  = ~r_skid_valid;
    assign o_out_valid = r_main_valid;
    assign {o_alu_op, o_imm, o_src_imm, o_rs1, o_rs2, o_rd, o_illegal} = r_main_data;

    assign w_accept    = i_in_valid & ~r_skid_valid;
    assign w_main_free = ~r_main_valid | i_out_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;

        if (i_flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_main_free) begin
            // Skid full implies no accept this cycle, so refill from skid first
            if (r_skid_valid) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = r_skid_data;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = w_enc;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = w_enc;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
        end
    end

endmodule
